// File: rtl/calc_operand_sequencer.sv
// Keypad operand sequencer feeding the 6-bit plus/minus adder.
// Builds two decimal operands and an operator from single-key events.
// Drives registered operands and control to the adder.
// Captures the adder's sum and carry/borrow, and supports result chaining.
module calc_operand_sequencer #(
   parameter int unsigned W = 6
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         key_valid,
   input  logic [3:0]   key_code,
   input  logic         mode,
   input  logic [W-1:0] adder_sum,
   input  logic [W-1:0] adder_cout,
   output logic [W-1:0] op_a,
   output logic [W-1:0] op_b,
   output logic         ctrl,
   output logic         mux_sel,
   output logic [W-1:0] result,
   output logic         carry_flag,
   output logic         res_valid,
   output logic         busy,
   output logic         key_err
);

   // Wide enough for 63*10+9 without wrapping.
   localparam int unsigned DW = W + 4;
   localparam logic [DW-1:0] MaxVal = DW'((1 << W) - 1);

   localparam logic [3:0] KeyPlus  = 4'd10;
   localparam logic [3:0] KeyMinus = 4'd11;
   localparam logic [3:0] KeyEq    = 4'd12;
   localparam logic [3:0] KeyClr   = 4'd13;

   typedef enum logic [1:0] {StA, StB, StExec, StRes} state_e;

   state_e       state_q, state_d;
   logic [W-1:0] op_a_q, op_a_d, op_b_q, op_b_d, result_q, result_d;
   logic         ctrl_q, ctrl_d, mux_sel_q, mux_sel_d, carry_q, carry_d;
   logic         res_valid_q, res_valid_d, busy_q, busy_d, key_err_q, key_err_d;
   logic         a_ent_q, a_ent_d, b_ent_q, b_ent_d;

   logic          is_digit, is_op, digit_ok;
   logic [W-1:0]  digit_base;
   logic [DW-1:0] digit_new;
   logic          unused_cout;

   // Only the MSB carry of the adder is meaningful here.
   assign unused_cout = ^adder_cout[W-2:0];

   // Decimal shift-in of the key digit into whichever operand is being entered.
   always_comb begin
      is_digit   = (key_code <= 4'd9);
      is_op      = (key_code == KeyPlus) || (key_code == KeyMinus);
      digit_base = (state_q == StB) ? op_b_q : op_a_q;
      digit_new  = {4'b0000, digit_base} * DW'(10) + {{(DW-4){1'b0}}, key_code};
      digit_ok   = (digit_new <= MaxVal);
   end

   // Next-state and output register computation.
   always_comb begin
      state_d     = state_q;
      op_a_d      = op_a_q;
      op_b_d      = op_b_q;
      ctrl_d      = ctrl_q;
      mux_sel_d   = mux_sel_q;
      result_d    = result_q;
      carry_d     = carry_q;
      res_valid_d = res_valid_q;
      a_ent_d     = a_ent_q;
      b_ent_d     = b_ent_q;
      key_err_d   = 1'b0;

      unique case (state_q)
         StA: begin
            if (key_valid) begin
               if (is_digit && digit_ok) begin
                  op_a_d  = digit_new[W-1:0];
                  a_ent_d = 1'b1;
               end else if (is_op && a_ent_q) begin
                  ctrl_d    = (key_code == KeyMinus);
                  mux_sel_d = mode;
                  op_b_d    = '0;
                  b_ent_d   = 1'b0;
                  state_d   = StB;
               end else begin
                  key_err_d = 1'b1;
               end
            end
         end
         StB: begin
            if (key_valid) begin
               if (is_digit && digit_ok) begin
                  op_b_d  = digit_new[W-1:0];
                  b_ent_d = 1'b1;
               end else if (is_op) begin
                  ctrl_d    = (key_code == KeyMinus);
                  mux_sel_d = mode;
               end else if (key_code == KeyEq && b_ent_q) begin
                  state_d = StExec;
               end else begin
                  key_err_d = 1'b1;
               end
            end
         end
         StExec: begin
            result_d    = adder_sum;
            carry_d     = adder_cout[W-1];
            res_valid_d = 1'b1;
            state_d     = StRes;
            key_err_d   = key_valid;
         end
         StRes: begin
            if (key_valid) begin
               if (is_digit) begin
                  op_a_d      = {{(W-4){1'b0}}, key_code};
                  op_b_d      = '0;
                  a_ent_d     = 1'b1;
                  b_ent_d     = 1'b0;
                  res_valid_d = 1'b0;
                  state_d     = StA;
               end else if (is_op) begin
                  op_a_d      = result_q;
                  ctrl_d      = (key_code == KeyMinus);
                  mux_sel_d   = mode;
                  op_b_d      = '0;
                  b_ent_d     = 1'b0;
                  res_valid_d = 1'b0;
                  state_d     = StB;
               end else if (key_code == KeyEq) begin
                  op_a_d      = result_q;
                  res_valid_d = 1'b0;
                  state_d     = StExec;
               end else begin
                  key_err_d = 1'b1;
               end
            end
         end
         default: state_d = StA;
      endcase

      // Clear overrides everything, including a key arriving during EXEC.
      if (key_valid && key_code == KeyClr) begin
         state_d     = StA;
         op_a_d      = '0;
         op_b_d      = '0;
         ctrl_d      = 1'b0;
         mux_sel_d   = 1'b0;
         result_d    = '0;
         carry_d     = 1'b0;
         res_valid_d = 1'b0;
         a_ent_d     = 1'b0;
         b_ent_d     = 1'b0;
         key_err_d   = 1'b0;
      end

      busy_d = (state_d == StExec);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StA;
         op_a_q      <= '0;
         op_b_q      <= '0;
         ctrl_q      <= 1'b0;
         mux_sel_q   <= 1'b0;
         result_q    <= '0;
         carry_q     <= 1'b0;
         res_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         key_err_q   <= 1'b0;
         a_ent_q     <= 1'b0;
         b_ent_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         ctrl_q      <= ctrl_d;
         mux_sel_q   <= mux_sel_d;
         result_q    <= result_d;
         carry_q     <= carry_d;
         res_valid_q <= res_valid_d;
         busy_q      <= busy_d;
         key_err_q   <= key_err_d;
         a_ent_q     <= a_ent_d;
         b_ent_q     <= b_ent_d;
      end
   end

   assign op_a       = op_a_q;
   assign op_b       = op_b_q;
   assign ctrl       = ctrl_q;
   assign mux_sel    = mux_sel_q;
   assign result     = result_q;
   assign carry_flag = carry_q;
   assign res_valid  = res_valid_q;
   assign busy       = busy_q;
   assign key_err    = key_err_q;

endmodule
